// File: rtl/uart_operand_loader.sv
// Receives 8N1 UART command frames (command byte, operand A, operand B, MSB first)
// and presents the select and operands as registered outputs once a frame completes cleanly.
module uart_operand_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int N            = 64,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx,
   output logic [1:0]   state,
   output logic [N-1:0] data_in1,
   output logic [N-1:0] data_in2,
   output logic         operands_valid,
   output logic         frame_err,
   output logic         busy
);

   localparam int NB  = N / 8;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BCW = $clog2(NB + 1);
   localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW  = $clog2(TMO + 1);

   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BCW-1:0] BYTE_LAST = BCW'(NB - 1);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TMO - 1);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
   typedef enum logic [1:0] {F_WAIT_CMD, F_LOAD_A, F_LOAD_B, F_COMMIT} frame_state_t;

   logic           rx_meta_q, rx_sync_q, rx_prev_q;
   bit_state_t     bstate_q;
   logic [CW-1:0]  bit_cnt_q;
   logic [2:0]     bit_idx_q;
   logic [7:0]     shift_q;
   logic           byte_valid_q, stop_err_q;

   frame_state_t   fstate_q;
   logic [1:0]     sel_q;
   logic [N-1:0]   a_q, b_q;
   logic [BCW-1:0] byte_cnt_q;
   logic [TW-1:0]  tmo_q;
   logic [1:0]     state_q;
   logic [N-1:0]   data_in1_q, data_in2_q;
   logic           operands_valid_q, frame_err_q, busy_q;

   logic [N-1:0]   a_shift_d, b_shift_d;

   assign a_shift_d = (a_q << 8) | {{(N-8){1'b0}}, shift_q};
   assign b_shift_d = (b_q << 8) | {{(N-8){1'b0}}, shift_q};

   assign state          = state_q;
   assign data_in1       = data_in1_q;
   assign data_in2       = data_in2_q;
   assign operands_valid = operands_valid_q;
   assign frame_err      = frame_err_q;
   assign busy           = busy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         bstate_q     <= B_IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
         case (bstate_q)
            B_IDLE: begin
               bit_cnt_q <= '0;
               if (rx_prev_q && !rx_sync_q) bstate_q <= B_START;
            end
            B_START: begin
               if (bit_cnt_q == HALF_LAST) begin
                  bit_cnt_q <= '0;
                  bit_idx_q <= '0;
                  // A start bit that is already high again at mid-bit is a glitch
                  bstate_q  <= rx_sync_q ? B_IDLE : B_DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            B_DATA: begin
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_q <= '0;
                  shift_q   <= {rx_sync_q, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) bstate_q <= B_STOP;
                  else bit_idx_q <= bit_idx_q + 1'b1;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            B_STOP: begin
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_q    <= '0;
                  bstate_q     <= B_IDLE;
                  byte_valid_q <= rx_sync_q;
                  stop_err_q   <= !rx_sync_q;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            default: bstate_q <= B_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fstate_q         <= F_WAIT_CMD;
         sel_q            <= '0;
         a_q              <= '0;
         b_q              <= '0;
         byte_cnt_q       <= '0;
         tmo_q            <= '0;
         state_q          <= '0;
         data_in1_q       <= '0;
         data_in2_q       <= '0;
         operands_valid_q <= 1'b0;
         frame_err_q      <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         operands_valid_q <= 1'b0;
         frame_err_q      <= 1'b0;
         case (fstate_q)
            F_WAIT_CMD: begin
               // Anything that is not a 0xA? command byte is dropped; this is the resync path
               if (byte_valid_q && shift_q[7:4] == 4'hA) begin
                  sel_q      <= shift_q[1:0];
                  byte_cnt_q <= '0;
                  tmo_q      <= '0;
                  busy_q     <= 1'b1;
                  fstate_q   <= F_LOAD_A;
               end
            end
            F_LOAD_A, F_LOAD_B: begin
               if (byte_valid_q) begin
                  tmo_q <= '0;
                  byte_cnt_q <= (byte_cnt_q == BYTE_LAST) ? '0 : byte_cnt_q + 1'b1;
                  if (fstate_q == F_LOAD_A) begin
                     a_q <= a_shift_d;
                     if (byte_cnt_q == BYTE_LAST) fstate_q <= F_LOAD_B;
                  end else begin
                     b_q <= b_shift_d;
                     if (byte_cnt_q == BYTE_LAST) begin
                        state_q          <= sel_q;
                        data_in1_q       <= a_q;
                        data_in2_q       <= b_shift_d;
                        operands_valid_q <= 1'b1;
                        fstate_q         <= F_COMMIT;
                     end
                  end
               end else if (stop_err_q || tmo_q == TMO_LAST) begin
                  frame_err_q <= 1'b1;
                  busy_q      <= 1'b0;
                  a_q         <= '0;
                  b_q         <= '0;
                  byte_cnt_q  <= '0;
                  tmo_q       <= '0;
                  fstate_q    <= F_WAIT_CMD;
               end else if (bstate_q == B_IDLE) begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            F_COMMIT: begin
               busy_q   <= 1'b0;
               fstate_q <= F_WAIT_CMD;
            end
            default: fstate_q <= F_WAIT_CMD;
         endcase
      end
   end

endmodule

// File: doc/uart_operand_loader.md
Name: uart_operand_loader

Overview:
- Upstream stage of the adder-select top level.
- Receives a serial 8N1 UART stream on rx and assembles command frames, each holding a 2-bit adder select and two 64-bit operands.
- Presents the frame contents as registered outputs, which drive the top level's state, data_in1 and data_in2 inputs directly.
- Outputs change only when a complete, error-free frame has been received.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Minimum 4.
- N, 64, operand width in bits. Must be a multiple of 8; operand byte count = N/8.
- TIMEOUT_BITS, 20, mid-frame idle limit in bit periods before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rx  in  1  UART serial input, idle high, asynchronous to clk
- state  out  2  adder select from the last accepted frame
- data_in1  out  N  operand A from the last accepted frame
- data_in2  out  N  operand B from the last accepted frame
- operands_valid  out  1  one-cycle pulse when state/data_in1/data_in2 update
- frame_err  out  1  one-cycle pulse when a frame is discarded (bad stop bit or timeout)
- busy  out  1  high while a frame is partially received

Behaviour:
- Reset (rst=0, async):
  - state, data_in1, data_in2, operands_valid, frame_err and busy all go to 0.
  - rx synchroniser flops go to 1.
  - Both FSMs go to their idle states; shadow registers and counters clear.
- rx passes through a 2-flop synchroniser. All sampling uses the synchronised value, so there are 2 cycles of latency.
- Bit FSM:
  - IDLE: a falling edge on synced rx goes to START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If low, go to DATA. If high, it was a glitch; return to IDLE with no byte and no error.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample = 1: byte_valid (internal) is high for exactly the following cycle.
    - Sample = 0: stop error.
  - After STOP, return to IDLE immediately. No wait for the end of the stop bit.
- Frame format: 1 + 2·(N/8) bytes.
  - Byte 0 is the command. Its upper nibble must be 0xA. Bits [3:2] are ignored; bits [1:0] are the select.
  - Then N/8 bytes of operand A, most-significant byte first.
  - Then N/8 bytes of operand B, MSB first.
- Frame FSM:
  - WAIT_CMD:
    - byte_valid with upper nibble 0xA: latch the select into the shadow, clear the byte counter, go to LOAD_A.
    - byte_valid with any other value: the byte is dropped silently; this is how the FSM resyncs.
    - A stop error here is also dropped silently, with no frame_err.
  - LOAD_A: shift each byte into the A shadow. On byte N/8, go to LOAD_B.
  - LOAD_B: shift into the B shadow. On the final byte, go to COMMIT.
  - COMMIT (1 cycle):
    - state, data_in1 and data_in2 load from the shadows on the same edge.
    - operands_valid is high for that cycle.
    - Return to WAIT_CMD.
- Latency: outputs are valid 2 clk edges after the mid-stop-bit sample of the last byte.
- busy is 1 in LOAD_A, LOAD_B and COMMIT, and 0 in WAIT_CMD.
- Stop error in LOAD_A or LOAD_B:
  - frame_err pulses for 1 cycle.
  - Shadows are discarded and the FSM returns to WAIT_CMD.
  - Outputs keep their previous values.
- Timeout:
  - In LOAD_A or LOAD_B, a counter runs while the bit FSM is in IDLE and clears on every byte_valid.
  - At TIMEOUT_BITS·CLKS_PER_BIT cycles, abort exactly as for a stop error, including the frame_err pulse.
- Back-to-back frames are accepted with zero idle between stop bit and next start bit. A new byte may arrive while in COMMIT; it is handled in WAIT_CMD the next cycle.
- Reset mid-frame: everything clears as in the reset bullet. The rest of the stream is treated as fresh traffic and resyncs on the next 0xA? byte.

Test Plan (CLKS_PER_BIT=16, N=64):
- Reset check: hold rst=0 with rx toggling -> all outputs 0. Release rst -> no pulses, busy=0.
- Good frame: send A1, 01 23 45 67 89 AB CD EF, 00×7 01 -> state=2'b01, data_in1=64'h0123456789ABCDEF, data_in2=64'h1. operands_valid is high exactly 1 cycle, 2 edges after the last mid-stop sample. busy falls in the following cycle.
- Glitch and resync:
  - Pull rx low for 6 cycles in idle -> no byte accepted, outputs unchanged.
  - Send byte 55, then the frame A2, A=FF…FF, B=00…02 -> 55 is ignored; state=2'b10, data_in1=all ones, data_in2=2.
- Stop error: after a good frame, corrupt the stop bit of operand A byte 3 -> frame_err pulses 1 cycle, outputs keep the prior frame's values. An immediately following good frame with A0 selects state=2'b00.
- Timeout: send A3 plus 3 bytes, then hold rx high -> frame_err at 20·16 cycles after the last byte_valid, busy=0, no operands_valid.
- Reset mid-frame: assert rst during operand B byte 4 -> outputs go to 0 asynchronously. The rest of the stream produces no operands_valid; the next full frame is accepted.
- Back-to-back: two good frames with no idle gap -> two operands_valid pulses, each with the correct values.
